// File: rtl/aes_pkg.sv
// Shared AES datapath types and GF(2^8) constant-coefficient multipliers (poly 0x11B).
package aes_pkg;

  localparam int COL_W   = 32;
  localparam int STATE_W = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fsm_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul2(input logic [7:0] b);
    return xtime(b);
  endfunction

  function automatic logic [7:0] gf_mul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gf_mul9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] gf_mulb(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gf_muld(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] gf_mule(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

endpackage

// File: rtl/mixcol_col.sv
// Combinational MixColumns / InvMixColumns of one 32-bit column (row 0 in bits [31:24]).
module mixcol_col
  import aes_pkg::*;
(
  input  logic [COL_W-1:0] in,
  input  logic             inv,
  output logic [COL_W-1:0] out
);

  logic [7:0] a0, a1, a2, a3;
  logic [7:0] f0, f1, f2, f3;
  logic [7:0] i0, i1, i2, i3;

  assign a0 = in[31:24];
  assign a1 = in[23:16];
  assign a2 = in[15:8];
  assign a3 = in[7:0];

  // Circulant matrix: each row rotates the coefficient set one position right.
  assign f0 = gf_mul2(a0) ^ gf_mul3(a1) ^ a2          ^ a3;
  assign f1 = a0          ^ gf_mul2(a1) ^ gf_mul3(a2) ^ a3;
  assign f2 = a0          ^ a1          ^ gf_mul2(a2) ^ gf_mul3(a3);
  assign f3 = gf_mul3(a0) ^ a1          ^ a2          ^ gf_mul2(a3);

  assign i0 = gf_mule(a0) ^ gf_mulb(a1) ^ gf_muld(a2) ^ gf_mul9(a3);
  assign i1 = gf_mul9(a0) ^ gf_mule(a1) ^ gf_mulb(a2) ^ gf_muld(a3);
  assign i2 = gf_muld(a0) ^ gf_mul9(a1) ^ gf_mule(a2) ^ gf_mulb(a3);
  assign i3 = gf_mulb(a0) ^ gf_muld(a1) ^ gf_mul9(a2) ^ gf_mule(a3);

  assign out = inv ? {i0, i1, i2, i3} : {f0, f1, f2, f3};

endmodule

// File: rtl/mixcol_engine.sv
// Sequential AES MixColumns engine, COLS_PER_CYCLE columns per BUSY cycle.
// Optional MIXCOL_BYPASS_EN adds in_bypass for the final round (no MixColumns).
module mixcol_engine
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_data,
  input  logic               in_inv,
`ifdef MIXCOL_BYPASS_EN
  input  logic               in_bypass,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_data
);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cpc
    $error("mixcol_engine: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_GRP = 2'(4 - COLS_PER_CYCLE);

  // Handshake: a block moves on any edge where valid and ready are both high;
  // in_ready is high only in IDLE, out_valid only in DONE, and out_data always
  // shows the state register so it stays stable while out_ready is low.
  fsm_t               fsm_q;
  logic [1:0]         col_cnt;
  logic [STATE_W-1:0] state_q;
  logic               mode_q;
  logic               ready_q;
  logic               valid_q;

  logic [1:0]         col_idx [COLS_PER_CYCLE];
  logic [COL_W-1:0]   col_in  [COLS_PER_CYCLE];
  logic [COL_W-1:0]   col_out [COLS_PER_CYCLE];
  logic [STATE_W-1:0] next_state;

  always_comb begin
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      col_idx[k] = col_cnt + 2'(k);
      col_in[k]  = '0;
      for (int c = 0; c < 4; c++) begin
        if (col_idx[k] == 2'(c)) col_in[k] = state_q[STATE_W-1-COL_W*c -: COL_W];
      end
    end
  end

  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
    mixcol_col u_col (
      .in  (col_in[k]),
      .inv (mode_q),
      .out (col_out[k])
    );
  end

  // Only the columns of the current group are replaced; the rest pass through.
  always_comb begin
    next_state = state_q;
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      for (int c = 0; c < 4; c++) begin
        if (col_idx[k] == 2'(c)) next_state[STATE_W-1-COL_W*c -: COL_W] = col_out[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      col_cnt <= '0;
      state_q <= '0;
      mode_q  <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (in_valid && ready_q) begin
            state_q <= in_data;
            mode_q  <= in_inv;
            col_cnt <= '0;
            ready_q <= 1'b0;
`ifdef MIXCOL_BYPASS_EN
            if (in_bypass) begin
              fsm_q   <= DONE;
              valid_q <= 1'b1;
            end else
`endif
            begin
              fsm_q <= BUSY;
            end
          end
        end
        BUSY: begin
          state_q <= next_state;
          if (col_cnt == LAST_GRP) begin
            col_cnt <= '0;
            fsm_q   <= DONE;
            valid_q <= 1'b1;
          end else begin
            col_cnt <= col_cnt + STEP;
          end
        end
        DONE: begin
          if (out_ready) begin
            fsm_q   <= IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          fsm_q   <= IDLE;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = valid_q;
  assign out_data  = state_q;

endmodule

// File: tb/tb_mixcol_engine.sv
// Bench for mixcol_engine: one instance per COLS_PER_CYCLE value (1, 2, 4),
// directed and random blocks checked against a matrix-form GF(2^8) model.
module tb_mixcol_engine;

  logic         clk;
  logic         rst_n;
  logic         in_valid_a [3];
  logic [127:0] in_data_a  [3];
  logic         in_inv_a   [3];
  logic         out_ready_a[3];
`ifdef MIXCOL_BYPASS_EN
  logic         in_bypass_a[3];
`endif
  wire  [2:0]   in_ready_v;
  wire  [2:0]   out_valid_v;
  wire  [127:0] out_data_v [3];

  int n_cmp = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mixcol_engine #(.COLS_PER_CYCLE(1 << g)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid_a[g]),
      .in_ready  (in_ready_v[g]),
      .in_data   (in_data_a[g]),
      .in_inv    (in_inv_a[g]),
`ifdef MIXCOL_BYPASS_EN
      .in_bypass (in_bypass_a[g]),
`endif
      .out_valid (out_valid_v[g]),
      .out_ready (out_ready_a[g]),
      .out_data  (out_data_v[g])
    );
  end

  // Reference: generic shift-and-add GF(2^8) product and a coefficient-matrix column transform.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic inv);
    logic [7:0]   coef [4];
    logic [7:0]   a    [4];
    logic [7:0]   acc;
    logic [127:0] r = '0;
    if (inv) coef = '{8'h0E, 8'h0B, 8'h0D, 8'h09};
    else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = s[127 - 32*c - 8*j -: 8];
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(coef[(j - row + 4) % 4], a[j]);
        r[127 - 32*c - 8*row -: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one block, waits (bounded) for out_valid; lat = edges after the accepting edge.
  task automatic run_block(input int d, input logic [127:0] data, input logic inv,
                           input logic toggle, output logic [127:0] res, output int lat);
    @(negedge clk);
    chk("pre_ready", 128'(in_ready_v[d]), 128'(1));
    in_data_a[d]  = data;
    in_inv_a[d]   = inv;
    in_valid_a[d] = 1'b1;
    @(posedge clk);
    #1;
    in_valid_a[d] = 1'b0;
    lat = 0;
    while (!out_valid_v[d] && lat < 16) begin
      if (toggle) in_inv_a[d] = ~in_inv_a[d];
      @(posedge clk);
      #1;
      lat++;
    end
    res = out_data_v[d];
  endtask

  task automatic drain(input int d);
    @(negedge clk);
    out_ready_a[d] = 1'b1;
    @(posedge clk);
    #1;
    out_ready_a[d] = 1'b0;
    chk("drain_ready", 128'(in_ready_v[d]), 128'(1));
    chk("drain_valid", 128'(out_valid_v[d]), 128'(0));
  endtask

  localparam logic [127:0] V1_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V1_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V2_IN  = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
  localparam logic [127:0] V2_OUT = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;

  initial begin
    logic [127:0] res, data, held;
    logic         inv;
    int           lat;

    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      in_valid_a[d]  = 1'b0;
      in_data_a[d]   = '0;
      in_inv_a[d]    = 1'b0;
      out_ready_a[d] = 1'b0;
`ifdef MIXCOL_BYPASS_EN
      in_bypass_a[d] = 1'b0;
`endif
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst_valid", 128'(out_valid_v[d]), 128'(0));
      chk("rst_data", out_data_v[d], '0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) chk("rst_ready", 128'(in_ready_v[d]), 128'(1));

    // Known vectors, forward and inverse round-trip, on every width
    for (int d = 0; d < 3; d++) begin
      run_block(d, V1_IN, 1'b0, 1'b0, res, lat);
      chk("fwd_v1", res, V1_OUT);
      chk("fwd_lat", 128'(lat), 128'(4 >> d));
      drain(d);
      run_block(d, res, 1'b1, 1'b0, res, lat);
      chk("inv_v1", res, V1_IN);
      chk("inv_lat", 128'(lat), 128'(4 >> d));
      drain(d);
      run_block(d, V2_IN, 1'b0, 1'b0, res, lat);
      chk("fwd_v2", res, V2_OUT);
      drain(d);
    end

    // Random blocks against the model
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 8; i++) begin
        data = rand128();
        inv  = 1'($urandom_range(0, 1));
        run_block(d, data, inv, 1'b0, res, lat);
        chk("rand_data", res, ref_mix(data, inv));
        chk("rand_lat", 128'(lat), 128'(4 >> d));
        drain(d);
      end
    end

    // Backpressure: result held, in_valid pulses ignored while DONE
    data = rand128();
    run_block(0, data, 1'b0, 1'b0, held, lat);
    chk("bp_first", held, ref_mix(data, 1'b0));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid_a[0] = 1'b1;
      in_data_a[0]  = rand128();
      in_inv_a[0]   = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      in_valid_a[0] = 1'b0;
      chk("bp_data", out_data_v[0], held);
      chk("bp_ready", 128'(in_ready_v[0]), 128'(0));
      chk("bp_valid", 128'(out_valid_v[0]), 128'(1));
    end
    // in_valid together with out_ready in DONE must not be accepted
    @(negedge clk);
    in_valid_a[0]  = 1'b1;
    in_data_a[0]   = ~held;
    out_ready_a[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid_a[0]  = 1'b0;
    out_ready_a[0] = 1'b0;
    chk("bp_rel_ready", 128'(in_ready_v[0]), 128'(1));
    chk("bp_rel_valid", 128'(out_valid_v[0]), 128'(0));
    chk("bp_rel_data", out_data_v[0], held);
    @(posedge clk);
    #1;
    chk("bp_idle_ready", 128'(in_ready_v[0]), 128'(1));

    // Reset after two BUSY edges on the 1-column instance
    @(negedge clk);
    in_data_a[0]  = rand128();
    in_inv_a[0]   = 1'b0;
    in_valid_a[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid_a[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 128'(out_valid_v[0]), 128'(0));
    chk("midrst_data", out_data_v[0], '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_ready", 128'(in_ready_v[0]), 128'(1));
    data = rand128();
    run_block(0, data, 1'b1, 1'b0, res, lat);
    chk("midrst_next", res, ref_mix(data, 1'b1));
    chk("midrst_lat", 128'(lat), 128'(4));
    drain(0);

    // Mode latched at acceptance despite in_inv toggling during BUSY
    for (int d = 0; d < 3; d++) begin
      for (int m = 0; m < 2; m++) begin
        data = rand128();
        run_block(d, data, 1'(m), 1'b1, res, lat);
        chk("mode_latch", res, ref_mix(data, 1'(m)));
        drain(d);
      end
    end

`ifdef MIXCOL_BYPASS_EN
    // Bypass: data unchanged, out_valid right after the accepting edge
    for (int d = 0; d < 3; d++) begin
      in_bypass_a[d] = 1'b1;
      run_block(d, 128'h00112233_44556677_8899aabb_ccddeeff, 1'b0, 1'b0, res, lat);
      in_bypass_a[d] = 1'b0;
      chk("byp_data", res, 128'h00112233_44556677_8899aabb_ccddeeff);
      chk("byp_lat", 128'(lat), 128'(0));
      drain(d);
      data = rand128();
      run_block(d, data, 1'b0, 1'b0, res, lat);
      chk("byp_after", res, ref_mix(data, 1'b0));
      drain(d);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
